npu_host_loader: RTL and testbench
==================================

Name: npu_host_loader

Overview:
Upstream host-side sequencer that drives the NPU memory-mapped port (ena/wea/addra/dina/douta) from a word-addressed source SRAM.
- On start, copies image, conv1/conv2 weights and fc2 weights into the NPU, then triggers the convolution.
- Then streams fc1 weights one 4-byte group at a time with the start_single/fc1_next/valid handshake.
- Finally polls done, reads the 24-bit logit and returns it sign-extended.

Parameters:
IMG_WORDS, 60, image words (240 B) written to sel 110
WC_WORDS, 23, words per conv weight set (90 B, last word partial) for sel 001 and 010
FC2_WORDS, 3, fc2 weight words (10 B) for sel 100
FC1_GROUPS, 330, fc1 weight words (132x10 B / 4 PE)
CONV_WAIT_CYC, 4096, fixed idle cycles between trigger write and first fc1 group
POLL_MAX, 1023, maximum status reads per poll before timeout
SRC_AW, 10, source SRAM word-address width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  single-cycle pulse; ignored unless idle
busy  out  1  high from accepted start until done/err
done  out  1  one-cycle pulse; result valid
err_timeout  out  1  one-cycle pulse; a poll exceeded POLL_MAX
result  out  32  sign-extended logit, held until next start
src_en  out  1  source SRAM read enable
src_addr  out  SRC_AW  source word address
src_rdata  in  32  source data, valid one cycle after src_en
npu_ena  out  1  NPU port enable
npu_wea  out  1  NPU write enable
npu_addra  out  16  {1'b0, sel[2:0], idx[11:0]}
npu_dina  out  32  NPU write data
npu_douta  in  32  NPU read data, combinational in the cycle ena=1, wea=0

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters cleared. Reset mid-run aborts with no further NPU access.
- Source layout, contiguous from word 0, in load order: image, conv1, conv2, fc2, fc1. Segment base = sum of the preceding sizes.
- States and transitions:
  - IDLE: start moves to LOAD.
  - LOAD:
    - Pipelined. Issue src_en at address k in cycle n. Write NPU word k (idx=k, segment sel) in cycle n+1 with npu_dina=src_rdata.
    - Sustained rate is 1 word/cycle. Segments are chained with no bubble except one pipeline fill.
  - TRIG: write sel 101, idx 1 (data 0).
  - CWAIT: count CONV_WAIT_CYC cycles.
  - G_LD: read src, write sel 011, idx 0.
  - G_ST: write 101/idx 2.
  - G_NX: write 101/idx 3.
  - G_POLL: read 111/idx 8 each cycle until bit0=1. Then increment the group counter. If groups remain, go to G_LD; otherwise go to D_POLL.
  - D_POLL: read 111/idx 0 until bit0=1.
  - RES: read 111/idx 4. result <= npu_douta. Pulse done. Return to IDLE.
- Only one NPU access per cycle. npu_ena=0 in all wait cycles. npu_wea asserted only together with npu_ena.
- Poll counter reset on entry to each poll state. If the count reaches POLL_MAX without bit0=1: pulse err_timeout, drop busy, return to IDLE, leave result unchanged.
- The NPU registers writes one cycle late. The first poll read is therefore issued no earlier than 2 cycles after the G_NX write; G_POLL inserts one idle cycle on entry.
- start while busy: ignored.
- start in the same cycle as done: ignored (the FSM is not IDLE in that cycle).

Optional Feature:
NPU_LOADER_PERF_EN
- Defined: adds output perf_cycles (32) counting cycles from accepted start to done/err. It saturates at 0xFFFFFFFF and is held until the next start.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package npu_loader_pkg holds:
  - state enum;
  - sel codes SEL_IMG=110, SEL_WC1=001, SEL_WC2=010, SEL_FC1=011, SEL_FC2=100, SEL_CTL=101, SEL_STAT=111;
  - control idx constants CTL_TRIG=1, CTL_START=2, CTL_NEXT=3;
  - status idx constants ST_DONE=0, ST_RES=4, ST_GVAL=8.
- One sub-module, loader_poll_timer: loadable down-counter shared by CWAIT and the polls, with an expired flag.

Test Plan:
- Full run against an NPU model with source = ramp data and model logit -5: 60+23+23+3 writes in order at the correct sel/idx, then trigger, then 330 groups; result=0xFFFFFFFB and a single done pulse.
- LOAD pipelining: check that image idx 0..59 appear on consecutive cycles with dina equal to source words 0..59, with no bubble at the image/conv1 boundary.
- fc1 handshake: model delays group valid by 7 cycles -> exactly 7+ poll reads, no G_ST write before the previous valid.
- Timeout: model never asserts done -> err_timeout pulses after POLL_MAX reads, busy=0, result keeps its previous value.
- start pulsed while busy and reset asserted mid-LOAD -> start ignored; after reset all outputs are 0 and no NPU access occurs until a new start.
- With NPU_LOADER_PERF_EN defined, a run with CONV_WAIT_CYC=16 -> perf_cycles equals the counted cycles from start to done.

Source files
------------

// File: rtl/npu_loader_pkg.sv
// Shared types and NPU address-map constants for the host-side NPU loader.
package npu_loader_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_TRIG, S_CWAIT, S_G_LD, S_G_ST, S_G_NX, S_G_POLL, S_D_POLL, S_RES
    } state_t;

    localparam logic [2:0] SEL_IMG  = 3'b110;
    localparam logic [2:0] SEL_WC1  = 3'b001;
    localparam logic [2:0] SEL_WC2  = 3'b010;
    localparam logic [2:0] SEL_FC1  = 3'b011;
    localparam logic [2:0] SEL_FC2  = 3'b100;
    localparam logic [2:0] SEL_CTL  = 3'b101;
    localparam logic [2:0] SEL_STAT = 3'b111;

    localparam logic [11:0] CTL_TRIG  = 12'd1;
    localparam logic [11:0] CTL_START = 12'd2;
    localparam logic [11:0] CTL_NEXT  = 12'd3;

    localparam logic [11:0] ST_DONE = 12'd0;
    localparam logic [11:0] ST_RES  = 12'd4;
    localparam logic [11:0] ST_GVAL = 12'd8;

    typedef struct packed {
        logic [2:0]  sel;
        logic [11:0] idx;
    } npu_loc_t;

    // Source word k of the load phase -> NPU segment and index within it.
    function automatic npu_loc_t load_loc(input int k, input int img, input int wc);
        npu_loc_t l;
        if (k < img) begin
            l.sel = SEL_IMG;
            l.idx = 12'(k);
        end else if (k < img + wc) begin
            l.sel = SEL_WC1;
            l.idx = 12'(k - img);
        end else if (k < img + 2 * wc) begin
            l.sel = SEL_WC2;
            l.idx = 12'(k - img - wc);
        end else begin
            l.sel = SEL_FC2;
            l.idx = 12'(k - img - 2 * wc);
        end
        return l;
    endfunction

endpackage

// File: rtl/npu_host_loader_poll_timer.sv
// Loadable down-counter shared by the convolution wait and the status polls.
module loader_poll_timer #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    input  logic         i_dec,
    output logic         o_expired
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_val;
        else if (i_dec && r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/npu_host_loader.sv
// Host sequencer: bulk-loads the NPU, streams fc1 groups, then fetches the logit.
// Optional cycle counter output enabled by NPU_LOADER_PERF_EN.
module npu_host_loader
    import npu_loader_pkg::*;
#(
    parameter int IMG_WORDS     = 60,
    parameter int WC_WORDS      = 23,
    parameter int FC2_WORDS     = 3,
    parameter int FC1_GROUPS    = 330,
    parameter int CONV_WAIT_CYC = 4096,
    parameter int POLL_MAX      = 1023,
    parameter int SRC_AW        = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic [31:0]       result,
    output logic              src_en,
    output logic [SRC_AW-1:0] src_addr,
    input  logic [31:0]       src_rdata,
    output logic              npu_ena,
    output logic              npu_wea,
    output logic [15:0]       npu_addra,
    output logic [31:0]       npu_dina,
    input  logic [31:0]       npu_douta
`ifdef NPU_LOADER_PERF_EN
    ,
    output logic [31:0]       perf_cycles
`endif
);

    localparam int LOAD_WORDS = IMG_WORDS + 2 * WC_WORDS + FC2_WORDS;
    localparam int TMAX       = (CONV_WAIT_CYC > POLL_MAX) ? CONV_WAIT_CYC : POLL_MAX;
    localparam int TW         = $clog2(TMAX + 1);

    localparam logic [SRC_AW:0]   LOAD_CNT  = (SRC_AW + 1)'(LOAD_WORDS);
    localparam logic [SRC_AW-1:0] FC1_BASE  = SRC_AW'(LOAD_WORDS);
    localparam logic [SRC_AW-1:0] GRP_LAST  = SRC_AW'(FC1_GROUPS - 1);
    localparam logic [TW-1:0]     CWAIT_LD  = TW'(CONV_WAIT_CYC - 1);
    localparam logic [TW-1:0]     POLL_LD   = TW'(POLL_MAX - 1);

    state_t            r_state, w_next;
    logic [SRC_AW:0]   r_cnt;
    logic              r_wvld;
    npu_loc_t          r_wloc;
    logic [SRC_AW-1:0] r_grp;
    logic              r_pidle;
    logic [31:0]       r_result;

    npu_loc_t          w_loc;
    logic [2:0]        w_sel;
    logic [11:0]       w_idx;
    logic              w_issue;
    logic              w_grp_adv;
    logic [SRC_AW-1:0] w_grp_nx;
    logic              w_tload;
    logic [TW-1:0]     w_tval;
    logic              w_tdec;
    logic              w_expired;
    logic [31:0]       w_logit;
    logic              w_unused_hi;

    assign w_loc       = load_loc(int'(r_cnt), IMG_WORDS, WC_WORDS);
    assign w_grp_nx    = r_grp + 1'b1;
    assign w_logit     = {{8{npu_douta[23]}}, npu_douta[23:0]};
    assign w_unused_hi = ^npu_douta[31:24];

    loader_poll_timer #(.W(TW)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_tload),
        .i_val     (w_tval),
        .i_dec     (w_tdec),
        .o_expired (w_expired)
    );

    always_comb begin
        w_next      = r_state;
        src_en      = 1'b0;
        src_addr    = '0;
        npu_ena     = 1'b0;
        npu_wea     = 1'b0;
        npu_dina    = '0;
        w_sel       = '0;
        w_idx       = '0;
        w_issue     = 1'b0;
        w_grp_adv   = 1'b0;
        w_tload     = 1'b0;
        w_tval      = '0;
        w_tdec      = 1'b0;
        done        = 1'b0;
        err_timeout = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_next = S_LOAD;
            S_LOAD: begin
                // Read word k while writing word k-1 fetched last cycle.
                if (r_cnt < LOAD_CNT) begin
                    src_en   = 1'b1;
                    src_addr = r_cnt[SRC_AW-1:0];
                    w_issue  = 1'b1;
                end
                if (r_wvld) begin
                    npu_ena  = 1'b1;
                    npu_wea  = 1'b1;
                    w_sel    = r_wloc.sel;
                    w_idx    = r_wloc.idx;
                    npu_dina = src_rdata;
                end
                if (r_cnt == LOAD_CNT) w_next = S_TRIG;
            end
            S_TRIG: begin
                npu_ena = 1'b1;
                npu_wea = 1'b1;
                w_sel   = SEL_CTL;
                w_idx   = CTL_TRIG;
                w_tload = 1'b1;
                w_tval  = CWAIT_LD;
                w_next  = S_CWAIT;
            end
            S_CWAIT: begin
                w_tdec = 1'b1;
                // Prefetch the first fc1 word so G_LD can write it directly.
                if (w_expired) begin
                    src_en   = 1'b1;
                    src_addr = FC1_BASE + r_grp;
                    w_next   = S_G_LD;
                end
            end
            S_G_LD: begin
                npu_ena  = 1'b1;
                npu_wea  = 1'b1;
                w_sel    = SEL_FC1;
                npu_dina = src_rdata;
                w_next   = S_G_ST;
            end
            S_G_ST: begin
                npu_ena = 1'b1;
                npu_wea = 1'b1;
                w_sel   = SEL_CTL;
                w_idx   = CTL_START;
                w_next  = S_G_NX;
            end
            S_G_NX: begin
                npu_ena = 1'b1;
                npu_wea = 1'b1;
                w_sel   = SEL_CTL;
                w_idx   = CTL_NEXT;
                w_tload = 1'b1;
                w_tval  = POLL_LD;
                w_next  = S_G_POLL;
            end
            S_G_POLL: begin
                // First cycle stays idle: the NX write lands in the NPU a cycle late.
                if (!r_pidle) begin
                    npu_ena = 1'b1;
                    w_sel   = SEL_STAT;
                    w_idx   = ST_GVAL;
                    if (npu_douta[0]) begin
                        w_grp_adv = 1'b1;
                        if (r_grp != GRP_LAST) begin
                            src_en   = 1'b1;
                            src_addr = FC1_BASE + w_grp_nx;
                            w_next   = S_G_LD;
                        end else begin
                            w_tload = 1'b1;
                            w_tval  = POLL_LD;
                            w_next  = S_D_POLL;
                        end
                    end else if (w_expired) begin
                        err_timeout = 1'b1;
                        w_next      = S_IDLE;
                    end else begin
                        w_tdec = 1'b1;
                    end
                end
            end
            S_D_POLL: begin
                npu_ena = 1'b1;
                w_sel   = SEL_STAT;
                w_idx   = ST_DONE;
                if (npu_douta[0]) begin
                    w_next = S_RES;
                end else if (w_expired) begin
                    err_timeout = 1'b1;
                    w_next      = S_IDLE;
                end else begin
                    w_tdec = 1'b1;
                end
            end
            S_RES: begin
                npu_ena = 1'b1;
                w_sel   = SEL_STAT;
                w_idx   = ST_RES;
                done    = 1'b1;
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_wvld   <= 1'b0;
            r_wloc   <= '0;
            r_grp    <= '0;
            r_pidle  <= 1'b0;
            r_result <= '0;
        end else begin
            r_state <= w_next;
            r_pidle <= (r_state == S_G_NX);
            r_wvld  <= w_issue;
            if (r_state == S_IDLE && start) begin
                r_cnt <= '0;
                r_grp <= '0;
            end
            if (w_issue) begin
                r_wloc <= w_loc;
                r_cnt  <= r_cnt + 1'b1;
            end
            if (w_grp_adv) r_grp <= w_grp_nx;
            if (r_state == S_RES) r_result <= w_logit;
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign npu_addra = {1'b0, w_sel, w_idx};
    // The logit is visible in the done cycle itself, then held.
    assign result    = (r_state == S_RES) ? w_logit : r_result;

`ifdef NPU_LOADER_PERF_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk) begin
        if (rst)
            r_perf <= '0;
        else if (r_state == S_IDLE) begin
            if (start) r_perf <= '0;
        end else if (r_perf != 32'hFFFF_FFFF)
            r_perf <= r_perf + 1'b1;
    end

    assign perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_npu_host_loader.sv
// Randomized bench for npu_host_loader against a behavioural NPU/source model.
module tb_npu_host_loader;

    localparam int CW  = 16;
    localparam int PM  = 1023;
    localparam int IMG = 60;
    localparam int WC  = 23;
    localparam int FC2 = 3;
    localparam int G   = 330;
    localparam int LW  = IMG + 2 * WC + FC2;
    localparam int BIG = 2147483647;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, err_timeout;
    logic [31:0] result;
    logic        src_en;
    logic [9:0]  src_addr;
    logic [31:0] src_rdata;
    logic        npu_ena, npu_wea;
    logic [15:0] npu_addra;
    logic [31:0] npu_dina, npu_douta;
`ifdef NPU_LOADER_PERF_EN
    logic [31:0] perf_cycles;
`endif

    npu_host_loader #(.CONV_WAIT_CYC(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .err_timeout(err_timeout), .result(result), .src_en(src_en),
        .src_addr(src_addr), .src_rdata(src_rdata), .npu_ena(npu_ena),
        .npu_wea(npu_wea), .npu_addra(npu_addra), .npu_dina(npu_dina),
        .npu_douta(npu_douta)
`ifdef NPU_LOADER_PERF_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Source SRAM: one-cycle read latency.
    logic [31:0] mem [0:1023];
    always @(posedge clk) if (src_en) src_rdata <= mem[src_addr];

    // NPU model: group-valid and done rise a programmable delay after the triggering write.
    int cyc = 0, gval_at = BIG, done_at = BIG, nx_cnt = 0;
    int gdly = 0, ddly = 0, logit = 0;
    bit never_done = 0, clr = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (clr) begin
            gval_at <= BIG; done_at <= BIG; nx_cnt <= 0;
        end else if (npu_ena && npu_wea && npu_addra[14:12] == 3'b101) begin
            if (npu_addra[11:0] == 12'd2) gval_at <= BIG;
            else if (npu_addra[11:0] == 12'd3) begin
                gval_at <= cyc + 1 + gdly;
                nx_cnt  <= nx_cnt + 1;
                if (nx_cnt + 1 == G && !never_done) done_at <= cyc + 1 + ddly;
            end
        end
    end

    always_comb begin
        npu_douta = '0;
        if (npu_ena && !npu_wea && npu_addra[14:12] == 3'b111) begin
            case (npu_addra[11:0])
                12'd8:   npu_douta = {31'h5EAD_0000, cyc >= gval_at};
                12'd0:   npu_douta = {31'h3C00_1230, cyc >= done_at};
                12'd4:   npu_douta = {8'hA5, 24'(logit)};
                default: npu_douta = 32'h0;
            endcase
        end
    end

    // Monitor: log NPU traffic away from the active edge.
    logic [2:0]  q_sel [$];
    logic [11:0] q_idx [$];
    logic [31:0] q_dat [$];
    int          q_cyc [$];
    int n_acc, n_gval, n_dpoll, n_res, n_done, n_err, n_busy, n_bad_we, n_order, n_st;
    bit gval_seen;
    logic [31:0] done_res;

    always @(negedge clk) begin
        if (clr) begin
            q_sel.delete(); q_idx.delete(); q_dat.delete(); q_cyc.delete();
            n_acc <= 0; n_gval <= 0; n_dpoll <= 0; n_res <= 0; n_done <= 0; n_err <= 0;
            n_busy <= 0; n_bad_we <= 0; n_order <= 0; n_st <= 0; gval_seen <= 0;
        end else begin
            if (npu_wea && !npu_ena) n_bad_we <= n_bad_we + 1;
            if (npu_ena) n_acc <= n_acc + 1;
            if (npu_ena && npu_wea) begin
                q_sel.push_back(npu_addra[14:12]); q_idx.push_back(npu_addra[11:0]);
                q_dat.push_back(npu_dina); q_cyc.push_back(cyc);
                if (npu_addra == 16'h5002) begin
                    if (n_st > 0 && !gval_seen) n_order <= n_order + 1;
                    n_st <= n_st + 1;
                    gval_seen <= 0;
                end
            end
            if (npu_ena && !npu_wea) begin
                if (npu_addra == 16'h7008) begin
                    n_gval <= n_gval + 1;
                    if (npu_douta[0]) gval_seen <= 1;
                end
                if (npu_addra == 16'h7000) n_dpoll <= n_dpoll + 1;
                if (npu_addra == 16'h7004) n_res <= n_res + 1;
            end
            if (done) begin n_done <= n_done + 1; done_res <= result; end
            if (err_timeout) n_err <= n_err + 1;
            if (busy) n_busy <= n_busy + 1;
        end
    end

    task automatic pulse_clr;
        @(posedge clk); #1 clr = 1;
        @(posedge clk); #1 clr = 0;
    endtask

    task automatic run_once(input bit poke, output bit fin);
        fin = 0;
        start = 1;
        @(posedge clk); #1 start = 0;
        for (int i = 0; i < 20000 && !fin; i++) begin
            @(posedge clk); #1 start = 0;
            if (poke && (i == 40 || done)) start = 1;
            if (!busy) fin = 1;
        end
        start = 0;
        n_cmp++;
        if (!fin) begin
            n_bad++;
            $display("FAIL run_bound: busy=%0b after 20000 cycles, want 0", busy);
        end
    endtask

    task automatic test_reset;
        rst = 1; start = 0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, err_timeout, src_en, npu_ena, npu_wea} !== 6'b0 || result !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_ctrl: flags=%b result=%h, want 0", {busy, done, err_timeout, src_en, npu_ena, npu_wea}, result);
        end
        n_cmp++;
        if (npu_addra !== 16'h0 || npu_dina !== 32'h0 || src_addr !== 10'h0) begin
            n_bad++;
            $display("FAIL reset_bus: addra=%h dina=%h src_addr=%h, want 0", npu_addra, npu_dina, src_addr);
        end
`ifdef NPU_LOADER_PERF_EN
        n_cmp++;
        if (perf_cycles !== 32'h0) begin n_bad++; $display("FAIL reset_perf: %0d, want 0", perf_cycles); end
`endif
        rst = 0;
    endtask

    task automatic test_full_run(input int gd, input int dd, input int lg);
        logic [2:0]  es [LW];
        logic [11:0] ei [LW];
        int seg_n [4] = '{IMG, WC, WC, FC2};
        logic [2:0] seg_s [4] = '{3'b110, 3'b001, 3'b010, 3'b100};
        int k = 0, pmin, b;
        bit fin;
        gdly = gd; ddly = dd; logit = lg; never_done = 0;
        pmin = (gd < 1) ? 1 : gd;
        for (int a = 0; a < 1024; a++) mem[a] = $urandom();
        for (int s = 0; s < 4; s++)
            for (int i = 0; i < seg_n[s]; i++) begin es[k] = seg_s[s]; ei[k] = 12'(i); k++; end
        pulse_clr;
        run_once(1, fin);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL start_at_done: busy=%0b, want 0", busy); end
        n_cmp++;
        if (q_sel.size() != LW + 1 + 3 * G) begin
            n_bad++;
            $display("FAIL write_count: %0d writes, want %0d", q_sel.size(), LW + 1 + 3 * G);
        end else begin
            for (int j = 0; j < LW; j++) begin
                n_cmp++;
                if ({q_sel[j], q_idx[j], q_dat[j]} !== {es[j], ei[j], mem[j]} || q_cyc[j] - q_cyc[0] != j) begin
                    n_bad++;
                    $display("FAIL load_word %0d: sel=%b idx=%0d dat=%h dcyc=%0d, want sel=%b idx=%0d dat=%h dcyc=%0d",
                             j, q_sel[j], q_idx[j], q_dat[j], q_cyc[j] - q_cyc[0], es[j], ei[j], mem[j], j);
                end
            end
            n_cmp++;
            if ({q_sel[LW], q_idx[LW], q_dat[LW]} !== {3'b101, 12'd1, 32'd0} || q_cyc[LW] != q_cyc[LW-1] + 1) begin
                n_bad++;
                $display("FAIL trigger: sel=%b idx=%0d dat=%h, want 101/1/0", q_sel[LW], q_idx[LW], q_dat[LW]);
            end
            n_cmp++;
            if (q_cyc[LW+1] - q_cyc[LW] != CW + 1) begin
                n_bad++;
                $display("FAIL conv_wait: gap=%0d, want %0d", q_cyc[LW+1] - q_cyc[LW], CW + 1);
            end
            for (int g = 0; g < G; g++) begin
                b = LW + 1 + 3 * g;
                n_cmp++;
                if ({q_sel[b], q_idx[b], q_dat[b]} !== {3'b011, 12'd0, mem[LW+g]} ||
                    {q_sel[b+1], q_idx[b+1], q_dat[b+1]} !== {3'b101, 12'd2, 32'd0} ||
                    {q_sel[b+2], q_idx[b+2], q_dat[b+2]} !== {3'b101, 12'd3, 32'd0} ||
                    q_cyc[b+1] != q_cyc[b] + 1 || q_cyc[b+2] != q_cyc[b] + 2 ||
                    (g < G - 1 && q_cyc[b+3] != q_cyc[b+2] + 2 + pmin)) begin
                    n_bad++;
                    $display("FAIL group %0d: ld=%b/%0d/%h st=%b/%0d nx=%b/%0d cyc=%0d,%0d,%0d, want data %h gap %0d",
                             g, q_sel[b], q_idx[b], q_dat[b], q_sel[b+1], q_idx[b+1], q_sel[b+2], q_idx[b+2],
                             q_cyc[b], q_cyc[b+1], q_cyc[b+2], mem[LW+g], 2 + pmin);
                end
            end
        end
        n_cmp++;
        if (n_gval != G * pmin) begin n_bad++; $display("FAIL gval_reads: %0d, want %0d", n_gval, G * pmin); end
        n_cmp++;
        if (n_dpoll != ((dd - pmin < 1) ? 1 : dd - pmin)) begin
            n_bad++; $display("FAIL done_reads: %0d, want %0d", n_dpoll, (dd - pmin < 1) ? 1 : dd - pmin);
        end
        n_cmp++;
        if (n_res != 1 || n_done != 1 || n_err != 0) begin
            n_bad++; $display("FAIL pulses: res_reads=%0d done=%0d err=%0d, want 1/1/0", n_res, n_done, n_err);
        end
        n_cmp++;
        if (done_res !== 32'(lg) || result !== 32'(lg)) begin
            n_bad++; $display("FAIL result: at_done=%h held=%h, want %h", done_res, result, 32'(lg));
        end
        n_cmp++;
        if (n_bad_we != 0 || n_order != 0) begin
            n_bad++; $display("FAIL protocol: wea_without_ena=%0d early_start=%0d, want 0/0", n_bad_we, n_order);
        end
`ifdef NPU_LOADER_PERF_EN
        n_cmp++;
        if (perf_cycles !== 32'(n_busy)) begin
            n_bad++; $display("FAIL perf_cycles: %0d, want %0d", perf_cycles, n_busy);
        end
`endif
    endtask

    task automatic test_timeout;
        logic [31:0] prev;
        bit fin;
        gdly = 1; ddly = 0; never_done = 1;
        logit = int'($urandom_range(0, 16777215)) - 8388608;
        prev = result;
        pulse_clr;
        run_once(0, fin);
        #1;
        n_cmp++;
        if (n_dpoll != PM || n_err != 1 || n_done != 0 || n_res != 0) begin
            n_bad++;
            $display("FAIL timeout: done_reads=%0d err=%0d done=%0d res_reads=%0d, want %0d/1/0/0", n_dpoll, n_err, n_done, n_res, PM);
        end
        n_cmp++;
        if (busy !== 1'b0 || result !== prev) begin
            n_bad++; $display("FAIL timeout_state: busy=%0b result=%h, want 0/%h", busy, result, prev);
        end
    endtask

    task automatic test_reset_mid_load;
        pulse_clr;
        start = 1;
        @(posedge clk); #1 start = 0;
        repeat (30) @(posedge clk);
        #1;
        n_cmp++;
        if (npu_ena !== 1'b1 || src_en !== 1'b1) begin
            n_bad++; $display("FAIL mid_load: npu_ena=%0b src_en=%0b, want 1/1", npu_ena, src_en);
        end
        rst = 1;
        @(posedge clk); #1 rst = 0;
        n_cmp++;
        if ({busy, done, err_timeout, src_en, npu_ena, npu_wea} !== 6'b0 || result !== 32'h0 || npu_addra !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_mid_load: flags=%b result=%h addra=%h, want 0", {busy, done, err_timeout, src_en, npu_ena, npu_wea}, result, npu_addra);
        end
        pulse_clr;
        repeat (40) @(posedge clk);
        #1;
        n_cmp++;
        if (n_acc != 0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL post_reset_quiet: accesses=%0d busy=%0b, want 0/0", n_acc, busy);
        end
`ifdef NPU_LOADER_PERF_EN
        n_cmp++;
        if (perf_cycles !== 32'h0) begin n_bad++; $display("FAIL reset_perf_mid: %0d, want 0", perf_cycles); end
`endif
    endtask

    initial begin
        test_reset;
        test_full_run(7, 3, -5);
        test_full_run(int'($urandom_range(0, 3)), int'($urandom_range(0, 20)),
                      int'($urandom_range(0, 16777215)) - 8388608);
        test_timeout;
        test_reset_mid_load;
        test_full_run(int'($urandom_range(1, 4)), int'($urandom_range(0, 9)),
                      int'($urandom_range(0, 16777215)) - 8388608);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
